// File: rtl/seg_pattern_monitor_if.sv
// Segment-bus monitor interface: sampled pattern and strobes in, decoded digit and status out.
// The monitor side uses the slave modport; the stimulus/driver side uses master.
interface seg_pattern_monitor_if #(
    parameter int CNT_W = 8
);
    logic [6:0]       segments;
    logic             enable;
    logic             clear_err;
    logic [3:0]       digit;
    logic             valid;
    logic             new_digit;
    logic             bad_pattern;
    logic             step_err;
    logic [CNT_W-1:0] step_count;

    modport master (
        output segments, enable, clear_err,
        input  digit, valid, new_digit, bad_pattern, step_err, step_count
    );

    modport slave (
        input  segments, enable, clear_err,
        output digit, valid, new_digit, bad_pattern, step_err, step_count
    );
endinterface

// File: rtl/seg_pattern_monitor.sv
// Debounces an active-low 7-segment bus, decodes stable patterns back to hex digits and
// checks +1 mod 16 stepping. Step checking (ref_ok/step_err/step_count) needs SEGMON_STEP_CHECK_EN.
module seg_pattern_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   clear,
    seg_pattern_monitor_if.slave   mon
);
    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

    state_t        state_reg;
    logic [6:0]    samp_reg;
    logic [SW-1:0] stab_reg;
    logic [3:0]    digit_reg;
    logic          valid_reg;
    logic          new_digit_reg;
    logic          bad_reg;

    logic [15:0]   hit;
    logic [3:0]    dec_digit;
    logic          dec_hit;

    // One comparator per table entry; the table is one-hot so the encoder needs no priority.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_dec
            assign hit[gi] = (samp_reg == SEG_TABLE[gi]);
        end
    endgenerate

    always_comb begin
        dec_digit = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (hit[i]) dec_digit = 4'(i);
        end
        dec_hit = |hit;
    end

`ifdef SEGMON_STEP_CHECK_EN
    logic             ref_ok_reg;
    logic             step_err_reg;
    logic [CNT_W-1:0] step_count_reg;
`endif

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_reg      <= IDLE;
            samp_reg       <= BLANK;
            stab_reg       <= '0;
            digit_reg      <= 4'd0;
            valid_reg      <= 1'b0;
            new_digit_reg  <= 1'b0;
            bad_reg        <= 1'b0;
`ifdef SEGMON_STEP_CHECK_EN
            ref_ok_reg     <= 1'b0;
            step_err_reg   <= 1'b0;
            step_count_reg <= '0;
`endif
        end else begin
            new_digit_reg <= 1'b0;
            // Clear first; any error raised below on this edge overrides it.
            if (mon.clear_err) begin
                bad_reg <= 1'b0;
`ifdef SEGMON_STEP_CHECK_EN
                step_err_reg <= 1'b0;
`endif
            end
            if (mon.enable) begin
                if (mon.segments != samp_reg) begin
                    samp_reg  <= mon.segments;
                    stab_reg  <= '0;
                    state_reg <= SETTLE;
                end else if (state_reg == SETTLE) begin
                    if (stab_reg < STAB_MAX) begin
                        stab_reg <= stab_reg + 1'b1;
                    end else begin
                        state_reg <= LOCKED;
                        if (dec_hit) begin
                            if (!valid_reg || dec_digit != digit_reg) begin
                                digit_reg     <= dec_digit;
                                valid_reg     <= 1'b1;
                                new_digit_reg <= 1'b1;
`ifdef SEGMON_STEP_CHECK_EN
                                if (step_count_reg != {CNT_W{1'b1}})
                                    step_count_reg <= step_count_reg + 1'b1;
                                if (ref_ok_reg && dec_digit != digit_reg + 4'd1)
                                    step_err_reg <= 1'b1;
                                ref_ok_reg <= 1'b1;
`endif
                            end
                        end else if (samp_reg != BLANK) begin
                            bad_reg <= 1'b1;
                        end
`ifdef SEGMON_STEP_CHECK_EN
                        // A blank breaks the sequence: the next digit is not step-checked.
                        if (samp_reg == BLANK)
                            ref_ok_reg <= 1'b0;
`endif
                    end
                end
            end
        end
    end

    assign mon.digit       = digit_reg;
    assign mon.valid       = valid_reg;
    assign mon.new_digit   = new_digit_reg;
    assign mon.bad_pattern = bad_reg;
`ifdef SEGMON_STEP_CHECK_EN
    assign mon.step_err    = step_err_reg;
    assign mon.step_count  = step_count_reg;
`else
    assign mon.step_err    = 1'b0;
    assign mon.step_count  = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_seg_pattern_monitor.sv
// Randomized and directed bench for seg_pattern_monitor against a run-length reference model.
module tb_seg_pattern_monitor;
    localparam int S     = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic clear = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   nd_seen = 0;

    always #5 clk = ~clk;

    seg_pattern_monitor_if #(.CNT_W(CNT_W)) bus ();

    seg_pattern_monitor #(.STABLE_CYCLES(S), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .clear (clear),
        .mon   (bus)
    );

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: a pattern is accepted once it has been present on S+1 enabled edges in a row.
    logic [6:0] m_pat;
    int         m_len;
    bit         m_done;
    int         m_digit;
    bit         m_valid, m_nd, m_bad, m_serr, m_ref;
    int         m_cnt;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // 0..15 digit, 16 blank, -1 invalid
    function automatic int lookup(input logic [6:0] p);
        if (p == 7'h7F) return 16;
        for (int i = 0; i < 16; i++) if (seg_tab[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pat = 7'h7F; m_len = 0; m_done = 1;
        m_digit = 0; m_valid = 0; m_nd = 0; m_bad = 0; m_serr = 0; m_ref = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic [6:0] seg, input bit en, input bit ce);
        bit nb = 0, ns = 0;
        int code;
        m_nd = 0;
        if (en) begin
            if (seg != m_pat) begin
                m_pat = seg; m_len = 1; m_done = 0;
            end else begin
                m_len++;
                if (!m_done && m_len == S + 1) begin
                    m_done = 1;
                    code = lookup(seg);
                    if (code >= 0 && code < 16) begin
                        if (!m_valid || code != m_digit) begin
                            if (m_ref && code != (m_digit + 1) % 16) ns = 1;
                            m_digit = code; m_valid = 1; m_nd = 1; m_ref = 1;
                            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                        end
                    end else if (code == 16) begin
                        m_ref = 0;
                    end else begin
                        nb = 1;
                    end
                end
            end
        end
        m_bad  = (m_bad && !ce) || nb;
        m_serr = (m_serr && !ce) || ns;
    endtask

    task automatic check_outputs(input string where);
        int exp_serr, exp_cnt;
`ifdef SEGMON_STEP_CHECK_EN
        exp_serr = int'(m_serr); exp_cnt = m_cnt;
`else
        exp_serr = 0; exp_cnt = 0;
`endif
        check({where, ".digit"},      int'(bus.digit),       m_digit);
        check({where, ".valid"},      int'(bus.valid),       int'(m_valid));
        check({where, ".new_digit"},  int'(bus.new_digit),   int'(m_nd));
        check({where, ".bad"},        int'(bus.bad_pattern), int'(m_bad));
        check({where, ".step_err"},   int'(bus.step_err),    exp_serr);
        check({where, ".step_count"}, int'(bus.step_count),  exp_cnt);
    endtask

    task automatic step(input logic [6:0] seg, input bit en, input bit ce);
        bus.segments = seg; bus.enable = en; bus.clear_err = ce;
        @(posedge clk);
        model_edge(seg, en, ce);
        #1;
        if (bus.new_digit) nd_seen++;
        check_outputs("cyc");
        bus.clear_err = 1'b0;
    endtask

    task automatic hold(input logic [6:0] seg, input int n);
        for (int i = 0; i < n; i++) step(seg, 1'b1, 1'b0);
    endtask

    initial begin
        int kind, len, d, code;
        logic [6:0] p;
        bit en, ce;

        bus.segments = 7'h7F; bus.enable = 1'b0; bus.clear_err = 1'b0;
        model_reset();
        #2 clear = 1'b0;
        #1 check_outputs("reset_async");
        repeat (2) @(posedge clk);
        #3 clear = 1'b1;
        check_outputs("reset_hold");

        // First digit: accepted on the 5th enabled edge.
        for (int e = 1; e <= 5; e++) begin
            step(7'h40, 1'b1, 1'b0);
            check("first.valid_timing", int'(bus.valid), (e == 5) ? 1 : 0);
        end
        hold(7'h40, 3);
        // Sweep 1..F then 0: 17 pulses in total.
        for (int k = 1; k <= 16; k++) hold(seg_tab[k % 16], 8);
        check("sweep.pulses", nd_seen, 17);
`ifdef SEGMON_STEP_CHECK_EN
        check("sweep.step_count", int'(bus.step_count), 17);
`endif
        check("sweep.step_err", int'(bus.step_err), 0);

        // Short glitch to 1 then back to 0: nothing accepted.
        nd_seen = 0;
        hold(7'h79, 2);
        hold(7'h40, 8);
        check("glitch.pulses", nd_seen, 0);
        check("glitch.digit", int'(bus.digit), 0);

        // Bad step 0 -> 2, clear it, then a bad step coincident with clear_err.
        hold(7'h24, 8);
        check("badstep.digit", int'(bus.digit), 2);
        step(7'h24, 1'b1, 1'b1);
        check("badstep.cleared", int'(bus.step_err), 0);
        hold(7'h79, 4);
        step(7'h79, 1'b1, 1'b1);
`ifdef SEGMON_STEP_CHECK_EN
        check("badstep.set_wins", int'(bus.step_err), 1);
`endif
        hold(7'h79, 3);
        step(7'h79, 1'b1, 1'b1);

        // Invalid pattern, then blank, then a non-successor digit that must not flag.
        hold(7'h7E, 6);
        check("invalid.bad", int'(bus.bad_pattern), 1);
        check("invalid.digit", int'(bus.digit), 1);
        hold(7'h7F, 8);
        hold(7'h19, 8);
        check("blank.no_step_err", int'(bus.step_err), 0);
        check("blank.digit", int'(bus.digit), 4);

        // Enable gap mid-settle delays acceptance by the gap length.
        hold(7'h12, 2);
        for (int i = 0; i < 10; i++) step(7'h12, 1'b0, 1'b0);
        hold(7'h12, 2);
        check("gap.not_yet", int'(bus.valid && bus.digit == 4'd5), 0);
        hold(7'h12, 1);
        check("gap.accepted", int'(bus.digit), 5);

        // Reset mid-settle discards the pending pattern.
        hold(7'h02, 3);
        #2 clear = 1'b0;
        #1;
        model_reset();
        check_outputs("reset_mid");
        bus.segments = 7'h7F;
        repeat (2) @(posedge clk);
        #3 clear = 1'b1;
        hold(7'h7F, 8);
        check("reset_mid.valid", int'(bus.valid), 0);

        // Randomized runs.
        for (int r = 0; r < 400; r++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 4)      p = seg_tab[(m_digit + 1) % 16];
            else if (kind <= 6) p = seg_tab[$urandom_range(0, 15)];
            else if (kind == 7) p = 7'h7F;
            else if (kind == 8) begin
                do begin
                    p = 7'($urandom_range(0, 127));
                    code = lookup(p);
                end while (code >= 0);
            end else p = seg_tab[m_digit];
            len = $urandom_range(1, 8);
            d = 0;
            while (d < len) begin
                en = ($urandom_range(0, 4) != 0);
                ce = en && ($urandom_range(0, 15) == 0);
                step(p, en, ce);
                if (en) d++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
